l2_message_receiver: RTL and testbench

L2-side receiver for the L1 protocol: accepts 62-bit L2 messages from the L1 data cache and the L1 instruction cache, arbitrates them into a single in-order FIFO, and presents them to the L2 model / trace logger over a valid/ready stream. It also keeps per-message-type statistics for the simulation report, alongside the caches' hit/miss counters.

---
 rtl/l2_msg_pkg.sv | 29 ++
 rtl/l2_msg_fifo.sv | 72 +++++++
 rtl/l2_message_receiver.sv | 115 +++++++++++
 tb/tb_l2_message_receiver.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_msg_pkg.sv
// Shared L1<->L2 message definitions: type codes, field positions and source ids.
package l2_msg_pkg;

    localparam int DEF_ADDR_W = 60;
    localparam int DEF_MSG_W  = DEF_ADDR_W + 2;

    localparam int TYPE_LSB = 0;
    localparam int TYPE_MSB = 1;
    localparam int ADDR_LSB = 2;

    typedef enum logic [1:0] {
        RETURNDATA = 2'd0,
        L2WRITE    = 2'd1,
        L2READ     = 2'd2,
        L2READFOWN = 2'd3
    } msg_type_e;

    typedef enum logic {
        SRC_D = 1'b0,
        SRC_I = 1'b1
    } src_e;

    localparam logic [63:0] CNT_MAX = '1;

    function automatic logic [63:0] sat_inc(input logic [63:0] v);
        return (v == CNT_MAX) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/l2_msg_fifo.sv
// Synchronous in-order FIFO; occupancy counter drives full/empty, pointers wrap mod DEPTH.
module l2_msg_fifo
    import l2_msg_pkg::*;
#(
    parameter int WIDTH = DEF_MSG_W + 1,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Empty head reads as zero so out_msg is defined straight out of reset.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/l2_message_receiver.sv
// L2-side receiver: round-robin merge of L1D/L1I messages into one FIFO, plus
// saturating per-type acceptance statistics.
module l2_message_receiver
    import l2_msg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    d_valid,
    input  logic [ADDR_W+1:0]       d_msg,
    output logic                    d_ready,
    input  logic                    i_valid,
    input  logic [ADDR_W+1:0]       i_msg,
    output logic                    i_ready,
    output logic                    out_valid,
    output logic [ADDR_W+1:0]       out_msg,
    output logic                    out_src,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic [63:0]             cnt_returndata,
    output logic [63:0]             cnt_write,
    output logic [63:0]             cnt_read,
    output logic [63:0]             cnt_readfown
);

    localparam int MSG_W = ADDR_W + 2;

    src_e             rr_q, rr_d;
    src_e             push_src;
    logic             d_acc, i_acc, push;
    logic [MSG_W-1:0] push_msg;
    logic [1:0]       push_type;
    logic [MSG_W:0]   fifo_dout;
    logic             fifo_full, fifo_empty;

    logic [63:0] cnt_ret_q, cnt_ret_d;
    logic [63:0] cnt_wr_q,  cnt_wr_d;
    logic [63:0] cnt_rd_q,  cnt_rd_d;
    logic [63:0] cnt_rfo_q, cnt_rfo_d;

    // A lone valid source takes the grant; rr only decides when both contend.
    always_comb begin
        d_ready   = ~fifo_full & (~i_valid | (d_valid & (rr_q == SRC_D)));
        i_ready   = ~fifo_full & (~d_valid | (i_valid & (rr_q == SRC_I)));
        d_acc     = d_valid & d_ready;
        i_acc     = i_valid & i_ready;
        push      = d_acc | i_acc;
        push_src  = i_acc ? SRC_I : SRC_D;
        push_msg  = i_acc ? i_msg : d_msg;
        push_type = push_msg[TYPE_MSB:TYPE_LSB];
        rr_d      = rr_q;
        if (d_valid & i_valid & ~fifo_full) begin
            rr_d = (rr_q == SRC_D) ? SRC_I : SRC_D;
        end
    end

    always_comb begin
        cnt_ret_d = cnt_ret_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_rd_d  = cnt_rd_q;
        cnt_rfo_d = cnt_rfo_q;
        if (push) begin
            case (push_type)
                RETURNDATA: cnt_ret_d = sat_inc(cnt_ret_q);
                L2WRITE:    cnt_wr_d  = sat_inc(cnt_wr_q);
                L2READ:     cnt_rd_d  = sat_inc(cnt_rd_q);
                default:    cnt_rfo_d = sat_inc(cnt_rfo_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q      <= SRC_D;
            cnt_ret_q <= '0;
            cnt_wr_q  <= '0;
            cnt_rd_q  <= '0;
            cnt_rfo_q <= '0;
        end else begin
            rr_q      <= rr_d;
            cnt_ret_q <= cnt_ret_d;
            cnt_wr_q  <= cnt_wr_d;
            cnt_rd_q  <= cnt_rd_d;
            cnt_rfo_q <= cnt_rfo_d;
        end
    end

    l2_msg_fifo #(
        .WIDTH (MSG_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_msg, push_src}),
        .pop   (out_ready),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign full           = fifo_full;
    assign out_valid      = ~fifo_empty;
    assign out_msg        = fifo_dout[MSG_W:1];
    assign out_src        = fifo_dout[0];
    assign cnt_returndata = cnt_ret_q;
    assign cnt_write      = cnt_wr_q;
    assign cnt_read       = cnt_rd_q;
    assign cnt_readfown   = cnt_rfo_q;

endmodule

// File: tb/tb_l2_message_receiver.sv
// Scoreboard bench for l2_message_receiver: queue-based reference model plus directed and random traffic.
module tb_l2_message_receiver;
    import l2_msg_pkg::*;

    localparam int AW    = 60;
    localparam int MW    = AW + 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          d_valid, i_valid, out_ready;
    logic [MW-1:0] d_msg, i_msg;
    logic          d_ready, i_ready, out_valid, out_src, full;
    logic [MW-1:0] out_msg;
    logic [3:0]    count;
    logic [63:0]   cnt_returndata, cnt_write, cnt_read, cnt_readfown;

    always #5 clk = ~clk;

    l2_message_receiver #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .d_valid        (d_valid),
        .d_msg          (d_msg),
        .d_ready        (d_ready),
        .i_valid        (i_valid),
        .i_msg          (i_msg),
        .i_ready        (i_ready),
        .out_valid      (out_valid),
        .out_msg        (out_msg),
        .out_src        (out_src),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .cnt_returndata (cnt_returndata),
        .cnt_write      (cnt_write),
        .cnt_read       (cnt_read),
        .cnt_readfown   (cnt_readfown)
    );

    typedef struct packed {
        logic [MW-1:0] msg;
        logic          src;
    } ent_t;

    ent_t        sb[$];
    logic [63:0] m_cnt [4];
    logic        m_rr_i;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    logic        d_fire, i_fire;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] rnd_msg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[MW-1:0];
    endfunction

    // Reference model: queue of expected entries, contention pointer, per-type counters.
    always @(negedge clk) begin : model
        int   occ;
        logic exp_d, exp_i, take_d, take_i;
        ent_t e;
        if (chk_en) begin
            occ = sb.size();
            check64("out_valid", out_valid, occ != 0);
            check64("count", count, occ);
            check64("full", full, occ == DEPTH);
            check64("cnt_returndata", cnt_returndata, m_cnt[0]);
            check64("cnt_write", cnt_write, m_cnt[1]);
            check64("cnt_read", cnt_read, m_cnt[2]);
            check64("cnt_readfown", cnt_readfown, m_cnt[3]);

            exp_d = 1'b0;
            exp_i = 1'b0;
            if (occ < DEPTH) begin
                if (d_valid && i_valid) begin
                    exp_d = !m_rr_i;
                    exp_i = m_rr_i;
                end else if (d_valid) begin
                    exp_d = 1'b1;
                end else if (i_valid) begin
                    exp_i = 1'b1;
                end else begin
                    exp_d = 1'b1;
                    exp_i = 1'b1;
                end
            end
            check64("d_ready", d_ready, exp_d);
            check64("i_ready", i_ready, exp_i);

            if (rst) begin
                sb.delete();
                for (int k = 0; k < 4; k++) m_cnt[k] = '0;
                m_rr_i = 1'b0;
            end else begin
                if (out_ready && occ > 0) begin
                    e = sb.pop_front();
                    check64("out_msg", out_msg, e.msg);
                    check64("out_src", out_src, e.src);
                end
                take_d = (occ < DEPTH) && d_valid && exp_d;
                take_i = (occ < DEPTH) && i_valid && exp_i;
                if (take_d || take_i) begin
                    e.msg = take_i ? i_msg : d_msg;
                    e.src = take_i;
                    sb.push_back(e);
                    if (m_cnt[e.msg[1:0]] != 64'hFFFF_FFFF_FFFF_FFFF)
                        m_cnt[e.msg[1:0]] = m_cnt[e.msg[1:0]] + 64'd1;
                end
                if ((occ < DEPTH) && d_valid && i_valid) m_rr_i = !m_rr_i;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        d_fire = d_valid && d_ready && !rst;
        i_fire = i_valid && i_ready && !rst;
        @(posedge clk);
        #1;
    endtask

    int sent;
    logic [63:0] sum0, w_ret, w_rd, w_rfo;

    initial begin
        for (int k = 0; k < 4; k++) m_cnt[k] = '0;
        m_rr_i    = 1'b0;
        rst       = 1'b1;
        d_valid   = 1'b0;
        i_valid   = 1'b0;
        d_msg     = '0;
        i_msg     = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check64("rst_out_msg", out_msg, '0);
        check64("rst_out_src", out_src, 1'b0);
        check64("rst_count", count, 0);

        // Single L2READ from L1D.
        out_ready = 1'b1;
        d_valid   = 1'b1;
        d_msg     = {60'h3865837, 2'd2};
        #1;
        check64("t1_d_ready", d_ready, 1'b1);
        tick();
        d_valid = 1'b0;
        check64("t1_out_valid", out_valid, 1'b1);
        check64("t1_out_msg", out_msg, {60'h3865837, 2'd2});
        check64("t1_out_src", out_src, 1'b0);
        check64("t1_cnt_read", cnt_read, 64'd1);
        tick();

        // Contention: grants alternate starting with L1D.
        d_valid = 1'b1; d_msg = rnd_msg();
        i_valid = 1'b1; i_msg = rnd_msg();
        for (int k = 0; k < 6; k++) begin
            tick();
            check64("t2_d_grant", d_fire, (k % 2) == 0);
            check64("t2_i_grant", i_fire, (k % 2) == 1);
            if (d_fire) d_msg = rnd_msg();
            if (i_fire) i_msg = rnd_msg();
        end
        d_valid = 1'b0;
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Fill with consumer stalled, then pop-without-push on full.
        out_ready = 1'b0;
        sum0 = cnt_returndata + cnt_write + cnt_read + cnt_readfown;
        sent = 0;
        d_valid = 1'b1; d_msg = rnd_msg();
        for (int k = 0; k < 20 && !full; k++) begin
            tick();
            if (d_fire) begin sent++; d_msg = rnd_msg(); end
        end
        check64("t3_sent_at_full", sent, 8);
        check64("t3_full", full, 1'b1);
        check64("t3_d_ready_full", d_ready, 1'b0);
        tick();
        check64("t3_no_accept", d_fire, 1'b0);
        out_ready = 1'b1;
        #1;
        check64("t4_ready_full_pop", d_ready, 1'b0);
        tick();
        check64("t4_no_push", d_fire, 1'b0);
        check64("t4_count7", count, 7);
        tick();
        check64("t4_push_next", d_fire, 1'b1);
        check64("t4_count_still7", count, 7);
        if (d_fire) begin sent++; d_msg = rnd_msg(); end
        for (int k = 0; k < 20 && sent < 10; k++) begin
            tick();
            if (d_fire) begin sent++; d_msg = rnd_msg(); end
        end
        d_valid = 1'b0;
        check64("t3_sent_total", sent, 10);
        check64("t3_cnt_total", cnt_returndata + cnt_write + cnt_read + cnt_readfown - sum0, 64'd10);
        for (int k = 0; k < 12; k++) tick();
        check64("t3_drained", count, 0);

        // Reset with 5 entries queued and L1D still valid.
        out_ready = 1'b0;
        sent = 0;
        d_valid = 1'b1; d_msg = rnd_msg();
        for (int k = 0; k < 20 && sent < 5; k++) begin
            tick();
            if (d_fire) begin sent++; d_msg = rnd_msg(); end
        end
        check64("t5_count5", count, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check64("t5_count", count, 0);
        check64("t5_out_valid", out_valid, 1'b0);
        check64("t5_cnt_sum", cnt_returndata | cnt_write | cnt_read | cnt_readfown, 64'd0);
        check64("t5_d_ready", d_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        d_valid = 1'b0;
        tick();

        // Saturation of the L2WRITE counter.
        force dut.cnt_wr_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cnt_wr_q;
        w_ret = cnt_returndata;
        w_rd  = cnt_read;
        w_rfo = cnt_readfown;
        d_valid = 1'b1;
        d_msg   = {rnd_msg() >> 2, 2'd1};
        tick();
        d_valid = 1'b0;
        check64("t6_accepted", d_fire, 1'b1);
        check64("t6_cnt_write_sat", cnt_write, 64'hFFFF_FFFF_FFFF_FFFF);
        check64("t6_ret_same", cnt_returndata, w_ret);
        check64("t6_rd_same", cnt_read, w_rd);
        check64("t6_rfo_same", cnt_readfown, w_rfo);
        tick();

        // Random traffic with holding sources, random back-pressure and rare resets.
        d_fire = 1'b0;
        i_fire = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if (!d_valid || d_fire) begin
                d_valid = ($urandom_range(0, 2) != 0);
                d_msg   = rnd_msg();
            end
            if (!i_valid || i_fire) begin
                i_valid = ($urandom_range(0, 2) != 0);
                i_msg   = rnd_msg();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst       = 1'b0;
        d_valid   = 1'b0;
        i_valid   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        check64("final_empty", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
